// File: rtl/game2048_pkg.sv
// Shared types and constants for the 2048 move path: one-hot directions,
// game_state encodings and the move scheduler state enum.
package game2048_pkg;

    typedef logic [3:0] dir_t;

    localparam dir_t DIR_NONE   = 4'b0000;
    localparam dir_t DIR_TOP    = 4'b0001;
    localparam dir_t DIR_BOTTOM = 4'b0010;
    localparam dir_t DIR_LEFT   = 4'b0100;
    localparam dir_t DIR_RIGHT  = 4'b1000;

    localparam logic [1:0] GS_BUSY = 2'b00;
    localparam logic [1:0] GS_IDLE = 2'b01;
    localparam logic [1:0] GS_WIN  = 2'b10;
    localparam logic [1:0] GS_LOSE = 2'b11;

    typedef enum logic [1:0] {
        WAIT_READY = 2'd0,
        ISSUE      = 2'd1,
        RELEASE    = 2'd2,
        DEAD       = 2'd3
    } sched_state_t;

    function automatic logic is_onehot(input dir_t d);
        return (d != DIR_NONE) && ((d & (d - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/move_cmd_scheduler_if.sv
// Move scheduler pins: requester inputs, game handshake and status flags.
// master = environment/game side, slave = scheduler.
interface move_cmd_scheduler_if #(
    parameter int FIFO_DEPTH = 4
) ();
    logic [3:0]                  btn_dir;
    logic                        kbd_valid;
    game2048_pkg::dir_t          kbd_dir;
    logic [1:0]                  game_state;
    game2048_pkg::dir_t          direction;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;
    logic                        overflow;
    logic                        kbd_err;
    logic                        game_over;

    modport master (
        output btn_dir, kbd_valid, kbd_dir, game_state,
        input  direction, fifo_level, overflow, kbd_err, game_over
    );

    modport slave (
        input  btn_dir, kbd_valid, kbd_dir, game_state,
        output direction, fifo_level, overflow, kbd_err, game_over
    );
endinterface

// File: rtl/move_cmd_scheduler_btn_debounce.sv
// One button: 2-FF sync, debounce counter, rising-edge pulse; MOVE_REPEAT_EN adds auto-repeat.
// Latency: rise pulses 2 + DEBOUNCE_CYCLES cycles after a stable press.
// Backpressure: none; pulses are single-cycle and must be captured by the caller.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic rise,
    output logic rpt
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
        $error("btn_debounce: cycle parameters must be at least 1");
    end

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    // cnt tracks how many consecutive samples have disagreed with level
    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            s1   <= btn_raw;
            s2   <= s1;
            rise <= 1'b0;
            if (s2 == level) begin
                cnt <= '0;
            end else if (cnt == DB_LAST) begin
                level <= s2;
                rise  <= s2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

`ifdef MOVE_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] rcnt;
    logic          first;

    always_ff @(posedge clk) begin
        if (rst || !level) begin
            rcnt  <= '0;
            first <= 1'b1;
            rpt   <= 1'b0;
        end else begin
            rpt <= 1'b0;
            if (rcnt == (first ? DELAY_LAST : PERIOD_LAST)) begin
                rpt   <= 1'b1;
                rcnt  <= '0;
                first <= 1'b0;
            end else begin
                rcnt <= rcnt + RW'(1);
            end
        end
    end
`else
    assign rpt = 1'b0;
`endif

endmodule

// File: rtl/move_cmd_scheduler.sv
// Round-robin merges button/keyboard moves into a FIFO and issues one per game IDLE (MOVE_REPEAT_EN: auto-repeat).
// Latency: kbd_valid to direction is 3 cycles with an empty FIFO and game_state=IDLE.
// Backpressure: full FIFO stalls the one-entry slots; a second event into a held slot overwrites it and sets overflow.
module move_cmd_scheduler
    import game2048_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int FIFO_DEPTH      = 4,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic                 clk,
    input  logic                 rst,
    move_cmd_scheduler_if.slave  bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("move_cmd_scheduler: FIFO_DEPTH must be a power of 2, at least 2");
    end

    logic [3:0] btn_level;
    logic [3:0] btn_rise;
    logic [3:0] btn_rpt;

    for (genvar g = 0; g < 4; g++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_debounce (
            .clk     (clk),
            .rst     (rst),
            .btn_raw (bus.btn_dir[g]),
            .level   (btn_level[g]),
            .rise    (btn_rise[g]),
            .rpt     (btn_rpt[g])
        );
    end

    logic btn_evt;
    dir_t btn_evt_dir;
    logic lower_held;

    // Lowest bit wins; a repeat only counts if no lower button is held.
    always_comb begin
        btn_evt     = 1'b0;
        btn_evt_dir = DIR_NONE;
        lower_held  = 1'b0;
        for (int b = 0; b < 4; b++) begin
            if (!btn_evt && (btn_rise[b] || (btn_rpt[b] && !lower_held))) begin
                btn_evt     = 1'b1;
                btn_evt_dir = dir_t'(4'b0001 << b);
            end
            lower_held = lower_held | btn_level[b];
        end
    end

    logic kbd_evt;
    assign kbd_evt = bus.kbd_valid && is_onehot(bus.kbd_dir);

    sched_state_t  state;
    dir_t          direction_q;
    logic          game_over_q;
    logic          overflow_q;
    logic          kbd_err_q;
    logic          btn_slot_vld;
    logic          kbd_slot_vld;
    dir_t          btn_slot;
    dir_t          kbd_slot;
    logic          rr_ptr;
    dir_t          mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] count;

    logic fifo_full;
    logic fifo_empty;
    logic flush;
    logic pick_kbd;
    logic push;
    logic pop;
    dir_t push_dat;
    dir_t head;

    assign fifo_full  = (count == FULL_LVL);
    assign fifo_empty = (count == '0);
    assign head       = mem[rd_ptr];
    // Flush on the very edge we enter DEAD so nothing leaks out afterwards.
    assign flush      = (state == DEAD) ||
                        (((state == WAIT_READY) || (state == ISSUE)) && bus.game_state[1]);
    assign pick_kbd   = kbd_slot_vld && (!btn_slot_vld || rr_ptr);
    assign push       = (btn_slot_vld || kbd_slot_vld) && !fifo_full && !flush;
    assign push_dat   = pick_kbd ? kbd_slot : btn_slot;
    assign pop        = (state == ISSUE) && (bus.game_state == GS_BUSY);

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_slot_vld <= 1'b0;
            kbd_slot_vld <= 1'b0;
            btn_slot     <= DIR_NONE;
            kbd_slot     <= DIR_NONE;
            rr_ptr       <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow_q   <= 1'b0;
            kbd_err_q    <= 1'b0;
            for (int j = 0; j < FIFO_DEPTH; j++) mem[j] <= DIR_NONE;
        end else begin
            if (bus.kbd_valid && !is_onehot(bus.kbd_dir)) kbd_err_q <= 1'b1;
            if (flush) begin
                btn_slot_vld <= 1'b0;
                kbd_slot_vld <= 1'b0;
                wr_ptr       <= '0;
                rd_ptr       <= '0;
                count        <= '0;
            end else begin
                if (push) begin
                    mem[wr_ptr] <= push_dat;
                    wr_ptr      <= wr_ptr + AW'(1);
                    if (btn_slot_vld && kbd_slot_vld) rr_ptr <= ~rr_ptr;
                end
                if (pop) rd_ptr <= rd_ptr + AW'(1);
                if (push && !pop)      count <= count + LW'(1);
                else if (!push && pop) count <= count - LW'(1);

                if (btn_evt) begin
                    btn_slot     <= btn_evt_dir;
                    btn_slot_vld <= 1'b1;
                    if (btn_slot_vld && !(push && !pick_kbd)) overflow_q <= 1'b1;
                end else if (push && !pick_kbd) begin
                    btn_slot_vld <= 1'b0;
                end

                if (kbd_evt) begin
                    kbd_slot     <= bus.kbd_dir;
                    kbd_slot_vld <= 1'b1;
                    if (kbd_slot_vld && !(push && pick_kbd)) overflow_q <= 1'b1;
                end else if (push && pick_kbd) begin
                    kbd_slot_vld <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= WAIT_READY;
            direction_q <= DIR_NONE;
            game_over_q <= 1'b0;
        end else begin
            case (state)
                WAIT_READY: begin
                    if (bus.game_state[1]) begin
                        state       <= DEAD;
                        game_over_q <= 1'b1;
                    end else if (bus.game_state == GS_IDLE && !fifo_empty) begin
                        state       <= ISSUE;
                        direction_q <= head;
                    end
                end
                ISSUE: begin
                    if (bus.game_state[1]) begin
                        state       <= DEAD;
                        direction_q <= DIR_NONE;
                        game_over_q <= 1'b1;
                    end else if (bus.game_state == GS_BUSY) begin
                        state       <= RELEASE;
                        direction_q <= DIR_NONE;
                    end
                end
                RELEASE: begin
                    if (bus.game_state != GS_BUSY) state <= WAIT_READY;
                end
                DEAD: begin
                    direction_q <= DIR_NONE;
                end
                default: state <= WAIT_READY;
            endcase
        end
    end

    assign bus.direction  = direction_q;
    assign bus.fifo_level = count;
    assign bus.overflow   = overflow_q;
    assign bus.kbd_err    = kbd_err_q;
    assign bus.game_over  = game_over_q;

endmodule

// File: tb/tb_move_cmd_scheduler.sv
// Directed bench for move_cmd_scheduler with a queue-based reference model
// stepped on every clock edge and compared on every falling edge.
module tb_move_cmd_scheduler;
    import game2048_pkg::*;

    localparam int DB    = 4;
    localparam int DEPTH = 4;
    localparam int PH_WAIT  = 0;
    localparam int PH_ISSUE = 1;
    localparam int PH_REL   = 2;
    localparam int PH_DEAD  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    move_cmd_scheduler_if #(.FIFO_DEPTH(DEPTH)) bus ();

    move_cmd_scheduler #(
        .DEBOUNCE_CYCLES (DB),
        .FIFO_DEPTH      (DEPTH),
        .REPEAT_DELAY    (60),
        .REPEAT_PERIOD   (30)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic       started = 1'b0;
    logic [3:0] m_s1, m_s2, m_lvl, m_rise;
    int         run [4];
    logic       m_bv, m_kv, m_rr;
    dir_t       m_b, m_k, m_dir;
    dir_t       m_q [$];
    int         m_ph;
    logic       m_ovf, m_kerr, m_over;

    task automatic model_step();
        logic bev;
        logic kev;
        logic dead_now;
        logic take_k;
        dir_t bdir;
        dir_t head;
        int   pre_size;
        logic [1:0] gs;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_lvl = '0; m_rise = '0;
            for (int i = 0; i < 4; i++) run[i] = 0;
            m_bv = 1'b0; m_kv = 1'b0; m_rr = 1'b0;
            m_b = '0; m_k = '0; m_dir = '0;
            m_q.delete();
            m_ph = PH_WAIT;
            m_ovf = 1'b0; m_kerr = 1'b0; m_over = 1'b0;
            started = 1'b1;
            return;
        end
        gs = bus.game_state;
        // A debounced rise seen at the last edge is the event offered now.
        bev = 1'b0;
        bdir = '0;
        for (int i = 0; i < 4; i++) begin
            if (!bev && m_rise[i]) begin
                bev  = 1'b1;
                bdir = 4'(1 << i);
            end
        end
        for (int i = 0; i < 4; i++) begin
            m_rise[i] = 1'b0;
            if (m_s2[i] != m_lvl[i]) begin
                run[i]++;
                if (run[i] == DB) begin
                    m_lvl[i]  = m_s2[i];
                    m_rise[i] = m_s2[i];
                    run[i]    = 0;
                end
            end else begin
                run[i] = 0;
            end
        end
        m_s2 = m_s1;
        m_s1 = bus.btn_dir;

        kev = bus.kbd_valid && ($countones(bus.kbd_dir) == 1);
        if (bus.kbd_valid && !kev) m_kerr = 1'b1;

        dead_now = (m_ph == PH_DEAD) || ((m_ph != PH_REL) && gs[1]);
        pre_size = m_q.size();
        head     = (pre_size > 0) ? m_q[0] : '0;
        if (dead_now) begin
            m_q.delete();
            m_bv = 1'b0;
            m_kv = 1'b0;
        end else begin
            if (m_ph == PH_ISSUE && gs == GS_BUSY) void'(m_q.pop_front());
            if ((m_bv || m_kv) && pre_size < DEPTH) begin
                take_k = m_kv && (!m_bv || m_rr);
                m_q.push_back(take_k ? m_k : m_b);
                if (m_bv && m_kv) m_rr = !m_rr;
                if (take_k) m_kv = 1'b0;
                else        m_bv = 1'b0;
            end
            if (bev) begin
                if (m_bv) m_ovf = 1'b1;
                m_bv = 1'b1;
                m_b  = bdir;
            end
            if (kev) begin
                if (m_kv) m_ovf = 1'b1;
                m_kv = 1'b1;
                m_k  = bus.kbd_dir;
            end
        end

        case (m_ph)
            PH_WAIT: begin
                if (gs[1]) begin
                    m_ph = PH_DEAD; m_over = 1'b1;
                end else if (gs == GS_IDLE && pre_size > 0) begin
                    m_ph = PH_ISSUE; m_dir = head;
                end
            end
            PH_ISSUE: begin
                if (gs[1]) begin
                    m_ph = PH_DEAD; m_over = 1'b1; m_dir = '0;
                end else if (gs == GS_BUSY) begin
                    m_ph = PH_REL; m_dir = '0;
                end
            end
            PH_REL: if (gs != GS_BUSY) m_ph = PH_WAIT;
            default: ;
        endcase
    endtask

    task automatic chk(input string name, input logic [3:0] got, input logic [3:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s at t=%0t: got %b, want %b", name, $time, got, want);
        end
    endtask

    task automatic compare();
        if (!started) return;
        chk("model_direction",  bus.direction, m_dir);
        chk("model_fifo_level", 4'(bus.fifo_level), 4'(m_q.size()));
        chk("model_overflow",   {3'b0, bus.overflow},  {3'b0, m_ovf});
        chk("model_kbd_err",    {3'b0, bus.kbd_err},   {3'b0, m_kerr});
        chk("model_game_over",  {3'b0, bus.game_over}, {3'b0, m_over});
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_dir(input int budget);
        int n;
        n = 0;
        while (bus.direction == 4'b0 && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic consume(input string name, input dir_t want);
        bus.game_state = GS_IDLE;
        wait_dir(12);
        chk(name, bus.direction, want);
        bus.game_state = GS_BUSY;
        tick();
        chk({name, "_release"}, bus.direction, 4'b0);
    endtask

    task automatic kbd_pulse(input dir_t d);
        bus.kbd_valid = 1'b1;
        bus.kbd_dir   = d;
        tick();
        bus.kbd_valid = 1'b0;
        bus.kbd_dir   = '0;
    endtask

    dir_t ovf_seq [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    dir_t ovf_out [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0010};

    initial begin
        bus.btn_dir    = '0;
        bus.kbd_valid  = 1'b0;
        bus.kbd_dir    = '0;
        bus.game_state = GS_BUSY;
        rst = 1'b1;
        ticks(3);
        rst = 1'b0;
        chk("reset_direction",  bus.direction, 4'b0);
        chk("reset_fifo_level", 4'(bus.fifo_level), 4'd0);
        chk("reset_overflow",   {3'b0, bus.overflow},  4'd0);
        chk("reset_kbd_err",    {3'b0, bus.kbd_err},   4'd0);
        chk("reset_game_over",  {3'b0, bus.game_over}, 4'd0);

        // Held left button: exactly one issued move
        bus.game_state = GS_IDLE;
        bus.btn_dir    = 4'b0100;
        ticks(6);
        bus.btn_dir = '0;
        wait_dir(12);
        chk("btn_left_dir", bus.direction, DIR_LEFT);
        chk("btn_left_level", 4'(bus.fifo_level), 4'd1);
        bus.game_state = GS_BUSY;
        tick();
        chk("btn_left_release", bus.direction, 4'b0);
        chk("btn_left_empty", 4'(bus.fifo_level), 4'd0);

        // Three-cycle glitch never survives debounce
        bus.game_state = GS_IDLE;
        bus.btn_dir    = 4'b0001;
        ticks(3);
        bus.btn_dir = '0;
        ticks(15);
        chk("glitch_dir", bus.direction, 4'b0);
        chk("glitch_level", 4'(bus.fifo_level), 4'd0);

        // Simultaneous button+keyboard: button first while rr_ptr=0
        bus.game_state = GS_BUSY;
        bus.btn_dir    = 4'b0001;
        ticks(6);
        bus.btn_dir = '0;
        kbd_pulse(DIR_RIGHT);
        ticks(3);
        chk("rr0_level", 4'(bus.fifo_level), 4'd2);
        consume("rr0_first", DIR_TOP);
        consume("rr0_second", DIR_RIGHT);

        // rr_ptr now 1: keyboard first
        bus.btn_dir = 4'b0010;
        ticks(6);
        bus.btn_dir = '0;
        kbd_pulse(DIR_RIGHT);
        ticks(3);
        chk("rr1_level", 4'(bus.fifo_level), 4'd2);
        consume("rr1_first", DIR_RIGHT);
        consume("rr1_second", DIR_BOTTOM);

        // Six back-to-back keys into a 4-deep FIFO with the game busy
        chk("ovf_before", {3'b0, bus.overflow}, 4'd0);
        for (int i = 0; i < 6; i++) begin
            bus.kbd_valid = 1'b1;
            bus.kbd_dir   = ovf_seq[i];
            tick();
        end
        bus.kbd_valid = 1'b0;
        bus.kbd_dir   = '0;
        ticks(2);
        chk("ovf_level", 4'(bus.fifo_level), 4'd4);
        chk("ovf_flag", {3'b0, bus.overflow}, 4'd1);
        for (int i = 0; i < 5; i++) consume($sformatf("ovf_drain%0d", i), ovf_out[i]);

        // Multi-hot keyboard code
        chk("kerr_before", {3'b0, bus.kbd_err}, 4'd0);
        kbd_pulse(4'b0110);
        tick();
        chk("kerr_flag", {3'b0, bus.kbd_err}, 4'd1);
        chk("kerr_level", 4'(bus.fifo_level), 4'd0);

        // Lose during ISSUE flushes everything and sticks in DEAD
        kbd_pulse(DIR_LEFT);
        kbd_pulse(DIR_TOP);
        ticks(3);
        bus.game_state = GS_IDLE;
        wait_dir(12);
        chk("dead_issue_dir", bus.direction, DIR_LEFT);
        chk("dead_issue_level", 4'(bus.fifo_level), 4'd2);
        bus.game_state = GS_LOSE;
        tick();
        chk("dead_dir", bus.direction, 4'b0);
        chk("dead_game_over", {3'b0, bus.game_over}, 4'd1);
        chk("dead_level", 4'(bus.fifo_level), 4'd0);
        kbd_pulse(DIR_RIGHT);
        bus.game_state = GS_IDLE;
        ticks(4);
        chk("dead_discard_level", 4'(bus.fifo_level), 4'd0);
        chk("dead_stuck", {3'b0, bus.game_over}, 4'd1);
        chk("dead_stuck_dir", bus.direction, 4'b0);

        // Reset leaves DEAD; WAIT_READY then shows the 3-cycle key latency
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_game_over", {3'b0, bus.game_over}, 4'd0);
        chk("rst2_overflow",  {3'b0, bus.overflow},  4'd0);
        chk("rst2_kbd_err",   {3'b0, bus.kbd_err},   4'd0);
        kbd_pulse(DIR_BOTTOM);
        chk("lat_cycle1", bus.direction, 4'b0);
        tick();
        chk("lat_cycle2", bus.direction, 4'b0);
        tick();
        chk("lat_cycle3", bus.direction, DIR_BOTTOM);
        bus.game_state = GS_BUSY;
        tick();
        chk("lat_release", bus.direction, 4'b0);
        ticks(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
